// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR decoder: FSM states, pulse-width windows
// in microseconds, and counter widths.
package ir_nec_pkg;

  localparam int CNT_W     = 14;
  localparam int BIT_CNT_W = 5;

  typedef logic [CNT_W-1:0] width_t;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

  localparam width_t LEAD_LO_MIN = 14'd8000;
  localparam width_t LEAD_LO_MAX = 14'd10000;
  localparam width_t LEAD_HI_MIN = 14'd4000;
  localparam width_t LEAD_HI_MAX = 14'd5000;
  localparam width_t REP_HI_MIN  = 14'd1800;
  localparam width_t REP_HI_MAX  = 14'd2700;
  localparam width_t BIT_LO_MIN  = 14'd400;
  localparam width_t BIT_LO_MAX  = 14'd700;
  localparam width_t ZERO_HI_MIN = 14'd400;
  localparam width_t ZERO_HI_MAX = 14'd700;
  localparam width_t ONE_HI_MIN  = 14'd1400;
  localparam width_t ONE_HI_MAX  = 14'd1900;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_LO,
    ST_LEAD_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_REP_STOP
  } state_e;

  function automatic logic in_window(input width_t w, input width_t lo, input width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronises the raw IR pin, detects its edges and measures the time
// spent at each level with a saturating microsecond counter.
module ir_pulse_timer
  import ir_nec_pkg::*;
(
  input  logic   clk_us,
  input  logic   rst_n,
  input  logic   ir_in,
  output logic   fall,
  output logic   rise,
  output width_t width
);

  logic   s1_q, s2_q, s3_q;
  width_t cnt_q, cnt_d;

  assign fall  = s3_q & ~s2_q;
  assign rise  = ~s3_q & s2_q;
  assign width = cnt_q;

  always_comb begin
    if (fall || rise) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_us or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sync stages reset to the idle (high) line level so no phantom edge follows reset.
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      s3_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= ir_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ir_remote_decoder.sv
// NEC IR frame decoder: classifies pulse widths, assembles the 32-bit frame,
// validates it and drives the command, repeat and sweep-hold outputs.
module ir_remote_decoder
  import ir_nec_pkg::*;
#(
  parameter logic [7:0] ADDR       = 8'h00,
  parameter logic [7:0] HOLD_KEY   = 8'h45,
  parameter int         TIMEOUT_US = 12000
) (
  input  logic       clk_us,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] cmd_code,
  output logic       cmd_valid,
  output logic       rep_valid,
  output logic       hold_out
);

  localparam width_t TIMEOUT_W = width_t'(TIMEOUT_US);

  logic   fall, rise;
  width_t width;

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [31:0]            sr_q, sr_d, sr_shift;
  logic [7:0]             cmd_code_q, cmd_code_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   rep_valid_q, rep_valid_d;
  logic                   hold_q, hold_d;
  logic                   last_ok_q, last_ok_d;
  logic                   is_zero, is_one, frame_ok;

  ir_pulse_timer u_timer (
    .clk_us (clk_us),
    .rst_n  (rst_n),
    .ir_in  (ir_in),
    .fall   (fall),
    .rise   (rise),
    .width  (width)
  );

  assign is_zero  = in_window(width, ZERO_HI_MIN, ZERO_HI_MAX);
  assign is_one   = in_window(width, ONE_HI_MIN, ONE_HI_MAX);
  // Bits arrive LSB first: addr, ~addr, cmd, ~cmd.
  assign sr_shift = {is_one, sr_q[31:1]};
  assign frame_ok = (sr_shift[7:0]   == ~sr_shift[15:8])
                 && (sr_shift[23:16] == ~sr_shift[31:24])
                 && (sr_shift[7:0]   == ADDR);

  // NOTE: every signal driven here gets a default first, otherwise an uncovered branch infers a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    cmd_code_d  = cmd_code_q;
    cmd_valid_d = 1'b0;
    rep_valid_d = 1'b0;
    hold_d      = hold_q;
    last_ok_d   = last_ok_q;

    if (state_q != ST_IDLE && width >= TIMEOUT_W) begin
      state_d   = ST_IDLE;
      last_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (fall) state_d = ST_LEAD_LO;
        ST_LEAD_LO: begin
          if (rise) begin
            state_d = in_window(width, LEAD_LO_MIN, LEAD_LO_MAX) ? ST_LEAD_HI : ST_IDLE;
          end
        end
        ST_LEAD_HI: begin
          if (fall) begin
            if (in_window(width, LEAD_HI_MIN, LEAD_HI_MAX)) begin
              state_d   = ST_BIT_LO;
              bit_cnt_d = '0;
            end else if (in_window(width, REP_HI_MIN, REP_HI_MAX)) begin
              state_d = ST_REP_STOP;
            end else begin
              state_d   = ST_IDLE;
              last_ok_d = 1'b0;
            end
          end
        end
        ST_BIT_LO: begin
          if (rise) begin
            if (in_window(width, BIT_LO_MIN, BIT_LO_MAX)) begin
              state_d = ST_BIT_HI;
            end else begin
              state_d   = ST_IDLE;
              last_ok_d = 1'b0;
            end
          end
        end
        ST_BIT_HI: begin
          if (fall) begin
            if (is_zero || is_one) begin
              sr_d = sr_shift;
              if (bit_cnt_q != LAST_BIT) begin
                state_d   = ST_BIT_LO;
                bit_cnt_d = bit_cnt_q + 1'b1;
              end else begin
                state_d = ST_IDLE;
                if (frame_ok) begin
                  cmd_code_d  = sr_shift[23:16];
                  cmd_valid_d = 1'b1;
                  last_ok_d   = 1'b1;
                  if (sr_shift[23:16] == HOLD_KEY) hold_d = ~hold_q;
                end else begin
                  last_ok_d = 1'b0;
                end
              end
            end else begin
              state_d   = ST_IDLE;
              last_ok_d = 1'b0;
            end
          end
        end
        ST_REP_STOP: begin
          if (rise) begin
            state_d = ST_IDLE;
            if (in_window(width, BIT_LO_MIN, BIT_LO_MAX)) begin
              rep_valid_d = last_ok_q;
            end else begin
              last_ok_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_us or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      cmd_code_q  <= '0;
      cmd_valid_q <= 1'b0;
      rep_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      last_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      cmd_code_q  <= cmd_code_d;
      cmd_valid_q <= cmd_valid_d;
      rep_valid_q <= rep_valid_d;
      hold_q      <= hold_d;
      last_ok_q   <= last_ok_d;
    end
  end

  assign cmd_code  = cmd_code_q;
  assign cmd_valid = cmd_valid_q;
  assign rep_valid = rep_valid_q;
  assign hold_out  = hold_q;

endmodule

// File: tb/tb_ir_remote_decoder.sv
// Scoreboard bench for ir_remote_decoder: drives NEC frames at real microsecond
// timing and compares every output pulse against an independent model.
`timescale 1ns/1ps
module tb_ir_remote_decoder;

  localparam logic [7:0] DUT_ADDR = 8'h00;
  localparam logic [7:0] DUT_HOLD = 8'h45;

  typedef enum int {M_NONE, M_BAD, M_TRUNC, M_RST} mode_e;

  typedef struct packed {
    logic       is_rep;
    logic [7:0] code;
    logic       hold;
  } exp_t;

  logic       clk_us = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ir_in  = 1'b1;
  logic [7:0] cmd_code;
  logic       cmd_valid;
  logic       rep_valid;
  logic       hold_out;

  exp_t       sb_q[$];
  exp_t       sb_e;
  int         checks_cnt = 0;
  int         errors_cnt = 0;
  logic [7:0] model_code = 8'h00;
  logic       model_hold = 1'b0;
  logic       model_last_ok = 1'b0;
  time        last_change = 0;
  logic       prev_pulse = 1'b0;

  ir_remote_decoder #(
    .ADDR       (DUT_ADDR),
    .HOLD_KEY   (DUT_HOLD),
    .TIMEOUT_US (12000)
  ) dut (
    .clk_us    (clk_us),
    .rst_n     (rst_n),
    .ir_in     (ir_in),
    .cmd_code  (cmd_code),
    .cmd_valid (cmd_valid),
    .rep_valid (rep_valid),
    .hold_out  (hold_out)
  );

  always #500 clk_us = ~clk_us;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk_us) begin
    if (cmd_valid || rep_valid) begin
      check("pulse_exclusive", 32'(cmd_valid & rep_valid), 32'd0);
      check("pulse_width", 32'(prev_pulse), 32'd0);
      check("latency", 32'(($time - last_change) / 1000), 32'd3);
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check("kind_rep", 32'(rep_valid), 32'(sb_e.is_rep));
        check("pulse_cmd_code", 32'(cmd_code), 32'(sb_e.code));
        check("pulse_hold_out", 32'(hold_out), 32'(sb_e.hold));
      end
    end
    prev_pulse <= cmd_valid | rep_valid;
  end

  task automatic line(input logic level, input int us);
    if (ir_in !== level) last_change = $time;
    ir_in = level;
    repeat (us) @(negedge clk_us);
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] addr_inv,
                            input logic [7:0] cmd, input logic [7:0] cmd_inv,
                            input mode_e mode, input int k);
    logic [31:0] data;
    bit          ok;
    data = {cmd_inv, cmd, addr_inv, addr};
    ok   = (addr == DUT_ADDR) && (addr_inv == ~addr) && (cmd_inv == ~cmd);
    if (mode == M_NONE) begin
      if (ok) begin
        if (cmd == DUT_HOLD) model_hold = ~model_hold;
        model_code    = cmd;
        model_last_ok = 1'b1;
        sb_q.push_back('{is_rep: 1'b0, code: cmd, hold: model_hold});
      end else begin
        model_last_ok = 1'b0;
      end
    end
    line(1'b0, 9000);
    line(1'b1, 4500);
    for (int i = 0; i < 32; i++) begin
      if (mode == M_RST && i == k) begin
        line(1'b0, 200);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd_code", 32'(cmd_code), 32'd0);
        check("midrst_hold_out", 32'(hold_out), 32'd0);
        check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("midrst_rep_valid", 32'(rep_valid), 32'd0);
        ir_in = 1'b1;
        last_change = $time;
        repeat (5) @(negedge clk_us);
        rst_n = 1'b1;
        model_code    = 8'h00;
        model_hold    = 1'b0;
        model_last_ok = 1'b0;
        line(1'b1, 2000);
        return;
      end
      line(1'b0, 560);
      if (mode == M_BAD && i == k) begin
        line(1'b1, 1100);
        line(1'b0, 560);
        line(1'b1, 2000);
        model_last_ok = 1'b0;
        return;
      end
      if (mode == M_TRUNC && i == k) begin
        line(1'b1, 15000);
        model_last_ok = 1'b0;
        return;
      end
      line(1'b1, data[i] ? 1690 : 560);
    end
    line(1'b0, 560);
    line(1'b1, 2000);
  endtask

  task automatic send_repeat();
    if (model_last_ok) sb_q.push_back('{is_rep: 1'b1, code: model_code, hold: model_hold});
    line(1'b0, 9000);
    line(1'b1, 2250);
    line(1'b0, 560);
    line(1'b1, 2000);
  endtask

  task automatic settle(input string name);
    repeat (20) @(negedge clk_us);
    check({name, "_drain"}, 32'(sb_q.size()), 32'd0);
    check({name, "_cmd_code"}, 32'(cmd_code), 32'(model_code));
    check({name, "_hold_out"}, 32'(hold_out), 32'(model_hold));
    sb_q.delete();
  endtask

  initial begin
    #1_500_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ir_in = 1'b1;
    repeat (5) @(negedge clk_us);
    check("rst_cmd_code", 32'(cmd_code), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_rep_valid", 32'(rep_valid), 32'd0);
    check("rst_hold_out", 32'(hold_out), 32'd0);
    rst_n = 1'b1;
    line(1'b1, 2000);

    // Hold key toggles hold_out on.
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, M_NONE, 0);
    settle("hold_on");

    // Reset in bit 20 of a hold-key frame discards it and clears outputs.
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, M_RST, 20);
    settle("midrst");

    // Next hold-key frame sets hold, an identical one clears it.
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, M_NONE, 0);
    settle("hold_again");
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, M_NONE, 0);
    settle("hold_off");

    // Accepted frame followed by a repeat.
    send_frame(8'h00, 8'hFF, 8'h18, 8'hE7, M_NONE, 0);
    send_repeat();
    settle("repeat");

    // Corrupt inverse byte: frame and following repeat both ignored.
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, M_NONE, 0);
    send_repeat();
    settle("corrupt");

    // Bad high width at bit 10 aborts; next good frame is accepted.
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, M_BAD, 10);
    send_frame(8'h00, 8'hFF, 8'h07, 8'hF8, M_NONE, 0);
    settle("abort_recover");

    // Truncated frame times out and clears last_ok, so the repeat is ignored.
    send_frame(8'h00, 8'hFF, 8'h07, 8'hF8, M_TRUNC, 15);
    send_repeat();
    settle("timeout");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
